// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
// Single-clock synchronous FIFO with arbitrary (non-power-of-2) depth,
// selectable standard or first-word-fall-through read mode, run-time
// programmable almost-empty/almost-full thresholds, a fill-level output,
// a synchronous flush and sticky overflow/underflow error flags.
//
// Ports:
//   clk          - clock, all logic on rising edge
//   rst          - synchronous active-high reset, overrides every other input
//   flush        - synchronous clear of pointers and level (errors retained)
//   data_in      - write data
//   wr_en        - write request
//   rd_en        - read request
//   ae_thresh    - almost-empty threshold (almost_empty = level <= ae_thresh)
//   af_thresh    - almost-full threshold (almost_full = level >= af_thresh)
//   err_clr      - clears sticky error flags
//   data_out     - read data (registered in standard mode, head word in FWFT)
//   empty/full   - level == 0 / level == DEPTH
//   almost_empty - level <= ae_thresh
//   almost_full  - level >= af_thresh
//   level        - number of stored words
//   overflow     - sticky: write attempted while full
//   underflow    - sticky: read attempted while empty
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12,
  parameter int FWFT       = 0,
  parameter int LW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [LW-1:0]         ae_thresh,
  input  logic [LW-1:0]         af_thresh,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_err;
  logic                  rd_err;

  // Status flags come straight from the registered level; thresholds are
  // compared live so a threshold change is visible in the same cycle.
  always_comb begin
    empty        = (level_q == '0);
    full         = (level_q == LW'(DEPTH));
    almost_empty = (level_q <= ae_thresh);
    almost_full  = (level_q >= af_thresh);
  end

  // Requests are accepted on the current flags; a flush cycle swallows both
  // requests entirely, so it neither accepts data nor raises an error.
  always_comb begin
    wr_acc = wr_en & ~full  & ~flush;
    rd_acc = rd_en & ~empty & ~flush;
    wr_err = wr_en &  full  & ~flush;
    rd_err = rd_en &  empty & ~flush;
  end

  // Pointers wrap by explicit compare because DEPTH need not be a power of 2.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
    end
  end

  // Level tracks accepted traffic; a simultaneous read and write cancel out.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      level_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Sticky error flags: a new error event takes priority over err_clr, and
  // flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_err) begin
        overflow_q <= 1'b1;
      end else if (err_clr) begin
        overflow_q <= 1'b0;
      end
      if (rd_err) begin
        underflow_q <= 1'b1;
      end else if (err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Standard mode registers the popped word (latency 1, holds otherwise);
  // FWFT mode exposes the head word combinationally.
  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_out_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_out_q <= '0;
        end else if (rd_acc) begin
          data_out_q <= mem[rd_ptr];
        end
      end

      assign data_out = data_out_q;
    end
  endgenerate

  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog
// Directed bench for sync_fifo_prog: one standard-mode instance (DEPTH=12)
// and one FWFT instance sharing clock, reset and control inputs but with
// their own read/write enables.
module tb_sync_fifo_prog;

  localparam int DW = 8;
  localparam int DEPTH = 12;
  localparam int LW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en_f = 1'b0;
  logic          rd_en_f = 1'b0;
  logic [LW-1:0] ae_thresh = LW'(2);
  logic [LW-1:0] af_thresh = LW'(10);
  logic          err_clr = 1'b0;

  logic [DW-1:0] data_out, data_out_f;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic          empty_f, full_f, almost_empty_f, almost_full_f, overflow_f, underflow_f;
  logic [LW-1:0] level, level_f;

  int checks = 0;
  int errors = 0;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .ae_thresh(ae_thresh), .af_thresh(af_thresh),
    .err_clr(err_clr), .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in),
    .wr_en(wr_en_f), .rd_en(rd_en_f), .ae_thresh(ae_thresh), .af_thresh(af_thresh),
    .err_clr(err_clr), .data_out(data_out_f), .empty(empty_f), .full(full_f),
    .almost_empty(almost_empty_f), .almost_full(almost_full_f), .level(level_f),
    .overflow(overflow_f), .underflow(underflow_f)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    apply_stimulus();
    apply_stimulus();
    rst = 1'b0;
    check_output("rst_empty", empty, 1);
    check_output("rst_full", full, 0);
    check_output("rst_level", level, 0);
    check_output("rst_ae", almost_empty, 1);
    check_output("rst_af", almost_full, 0);
    check_output("rst_ovf", overflow, 0);
    check_output("rst_udf", underflow, 0);
    check_output("rst_dout", data_out, 0);
    af_thresh = LW'(0);
    #1;
    check_output("rst_af_thresh0", almost_full, 1);
    af_thresh = LW'(10);
    #1;

    // ---------------- fill 0x01..0x0C with threshold checks ----------------
    $display("[TB] fill to full");
    wr_en = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      data_in = DW'(i);
      apply_stimulus();
      check_output("fill_level", level, i);
      check_output("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
      check_output("fill_af", almost_full, (i >= 10) ? 1 : 0);
      if (i == 9) begin
        af_thresh = LW'(9);
        #1;
        check_output("af_live_change", almost_full, 1);
        af_thresh = LW'(10);
        #1;
      end
    end
    check_output("full_after12", full, 1);
    data_in = 8'hFF;
    apply_stimulus();
    wr_en = 1'b0;
    check_output("ovf_set", overflow, 1);
    check_output("ovf_level", level, 12);
    check_output("ovf_full", full, 1);

    // ---------------- drain, 0xFF must not appear ----------------
    rd_en = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      apply_stimulus();
      check_output("drain_data", data_out, i);
      check_output("drain_level", level, DEPTH - i);
    end
    rd_en = 1'b0;
    check_output("drain_empty", empty, 1);
    apply_stimulus();
    check_output("dout_hold", data_out, 8'h0C);
    check_output("no_udf", underflow, 0);
    err_clr = 1'b1;
    apply_stimulus();
    err_clr = 1'b0;
    check_output("ovf_cleared", overflow, 0);

    // ---------------- pointer wrap across 11->0 ----------------
    $display("[TB] pointer wrap");
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = DW'(8'h20 + i);
      apply_stimulus();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus();
      check_output("wrap8_data", data_out, 8'h20 + i);
    end
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = DW'(8'h30 + i);
      apply_stimulus();
    end
    wr_en = 1'b0;
    check_output("wrap10_level", level, 10);
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus();
      check_output("wrap10_data", data_out, 8'h30 + i);
    end
    rd_en = 1'b0;
    check_output("wrap_level0", level, 0);
    check_output("wrap_no_ovf", overflow, 0);
    check_output("wrap_no_udf", underflow, 0);

    // ---------------- simultaneous read and write ----------------
    $display("[TB] simultaneous rd/wr");
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 8'h55;
    apply_stimulus();
    rd_en = 1'b0;
    check_output("sim0_level", level, 1);
    check_output("sim0_udf", underflow, 1);
    check_output("sim0_dout_hold", data_out, 8'h39);
    for (int i = 0; i < 11; i++) begin
      data_in = DW'(8'h60 + i);
      apply_stimulus();
    end
    check_output("sim12_full", full, 1);
    rd_en = 1'b1;
    data_in = 8'h77;
    apply_stimulus();
    wr_en = 1'b0;
    check_output("sim12_level", level, 11);
    check_output("sim12_ovf", overflow, 1);
    check_output("sim12_dout", data_out, 8'h55);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus();
      check_output("sim_drain6", data_out, 8'h60 + i);
    end
    check_output("sim5_pre_level", level, 5);
    wr_en = 1'b1;
    data_in = 8'h88;
    apply_stimulus();
    wr_en = 1'b0;
    check_output("sim5_level", level, 5);
    check_output("sim5_dout", data_out, 8'h66);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus();
      check_output("sim5_order", data_out, 8'h67 + i);
    end
    apply_stimulus();
    rd_en = 1'b0;
    check_output("sim5_last", data_out, 8'h88);
    check_output("sim5_empty", level, 0);
    // err_clr together with a fresh underflow: set wins
    err_clr = 1'b1;
    rd_en = 1'b1;
    apply_stimulus();
    rd_en = 1'b0;
    check_output("set_wins_udf", underflow, 1);
    check_output("clr_ovf", overflow, 0);
    apply_stimulus();
    err_clr = 1'b0;
    check_output("clr_udf", underflow, 0);

    // ---------------- flush with overflow set at level 7 ----------------
    $display("[TB] flush");
    wr_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      data_in = DW'(8'h90 + i);
      apply_stimulus();
    end
    wr_en = 1'b0;
    check_output("pre_flush_ovf", overflow, 1);
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus();
    end
    rd_en = 1'b0;
    check_output("pre_flush_level", level, 7);
    check_output("pre_flush_dout", data_out, 8'h94);
    flush = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 8'hEE;
    apply_stimulus();
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_output("flush_level", level, 0);
    check_output("flush_empty", empty, 1);
    check_output("flush_ovf_kept", overflow, 1);
    check_output("flush_no_udf", underflow, 0);
    check_output("flush_dout_hold", data_out, 8'h94);
    flush = 1'b1;
    rd_en = 1'b1;
    apply_stimulus();
    flush = 1'b0;
    rd_en = 1'b0;
    check_output("flush_rd_ignored", underflow, 0);
    wr_en = 1'b1;
    data_in = 8'hAB;
    apply_stimulus();
    wr_en = 1'b0;
    check_output("post_flush_level", level, 1);
    rd_en = 1'b1;
    apply_stimulus();
    rd_en = 1'b0;
    check_output("post_flush_data", data_out, 8'hAB);
    err_clr = 1'b1;
    apply_stimulus();
    err_clr = 1'b0;
    check_output("flush_errclr", overflow, 0);

    // ---------------- reset mid-burst ----------------
    $display("[TB] reset mid-burst");
    rd_en = 1'b1;
    apply_stimulus();
    rd_en = 1'b0;
    check_output("pre_rst_udf", underflow, 1);
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = DW'(8'hC0 + i);
      apply_stimulus();
    end
    check_output("pre_rst_level", level, 3);
    rst = 1'b1;
    rd_en = 1'b1;
    apply_stimulus();
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_output("midrst_level", level, 0);
    check_output("midrst_empty", empty, 1);
    check_output("midrst_udf", underflow, 0);
    check_output("midrst_dout", data_out, 0);

    // ---------------- FWFT instance ----------------
    $display("[TB] FWFT mode");
    check_output("fwft_rst_empty", empty_f, 1);
    wr_en_f = 1'b1;
    data_in = 8'hA5;
    apply_stimulus();
    wr_en_f = 1'b0;
    check_output("fwft_nonempty", empty_f, 0);
    check_output("fwft_head", data_out_f, 8'hA5);
    apply_stimulus();
    check_output("fwft_head_hold", data_out_f, 8'hA5);
    rd_en_f = 1'b1;
    apply_stimulus();
    rd_en_f = 1'b0;
    check_output("fwft_pop_empty", empty_f, 1);
    check_output("fwft_pop_level", level_f, 0);
    wr_en_f = 1'b1;
    data_in = 8'h11;
    apply_stimulus();
    data_in = 8'h22;
    apply_stimulus();
    wr_en_f = 1'b0;
    check_output("fwft_head2", data_out_f, 8'h11);
    rd_en_f = 1'b1;
    apply_stimulus();
    rd_en_f = 1'b0;
    check_output("fwft_next", data_out_f, 8'h22);
    check_output("fwft_level1", level_f, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock synchronous FIFO, next generation of the team's buffering primitive.
- Arbitrary (non-power-of-2) depth.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Run-time programmable almost-empty/almost-full thresholds and a fill-level output.
- Synchronous flush, plus sticky overflow/underflow error flags with explicit clear.
- Used between bus-side and pixel/stream-side logic in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each data word
DEPTH, 12, number of storage words; any integer >= 2
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
LW, $clog2(DEPTH+1), width of level and threshold signals (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of FIFO contents
data_in  in  DATA_WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request
ae_thresh  in  LW  almost-empty threshold
af_thresh  in  LW  almost-full threshold
err_clr  in  1  clears sticky error flags
data_out  out  DATA_WIDTH  read data
empty  out  1  no words stored
full  out  1  level == DEPTH
almost_empty  out  1  level <= ae_thresh
almost_full  out  1  level >= af_thresh
level  out  LW  number of stored words
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Clears write pointer, read pointer, level, overflow, underflow, and data_out (standard mode).
  - After reset: empty=1, full=0, level=0, almost_empty=1 (ae_thresh >= 0), almost_full = (af_thresh == 0).
  - rst overrides every other input, including mid-operation.
- Acceptance, decided on current-cycle flags:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
  - No write-through on full, no read-through on empty.
- Level update: level_next = level + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves level unchanged.
  - Level never exceeds DEPTH and never underflows.
- Pointers:
  - Each pointer advances by 1 on its accept and wraps from DEPTH-1 to 0 (explicit compare, not power-of-2 rollover).
  - Pointer width is $clog2(DEPTH).
- Memory write: mem[wr_ptr] <= data_in on wr_acc.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr], valid the cycle after rd_en; read latency 1.
  - data_out holds its value when there is no rd_acc.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; head word visible whenever empty=0.
  - rd_en acknowledges/pops the head.
  - A write into an empty FIFO makes empty=0 and data_out valid on the next cycle.
  - data_out is undefined while empty=1; the bench must not check it then.
- Flags are combinational from registered level: empty, full, almost_empty, almost_full.
  - Thresholds are sampled live; a threshold change takes effect in the same cycle.
- Flush (rst=0):
  - Next cycle: pointers and level = 0.
  - All wr_en/rd_en in the flush cycle are ignored (no accept, no error set).
  - Sticky error flags are retained; memory contents are not cleared.
- Errors:
  - overflow set on wr_en & full; underflow set on rd_en & empty; sticky.
  - err_clr clears them next cycle.
  - If err_clr and a new error event coincide, set wins.
  - Rejected requests never change pointers, level, or data_out.

Test Plan:
- DEPTH=12, FWFT=0: write 0x01..0x0C, then 13th write 0xFF -> full=1 after 12th, level=12, overflow=1, 0xFF dropped; 12 reads return 0x01..0x0C each one cycle after rd_en, then empty=1.
- Pointer wrap, non-power-of-2: write 8, read 8, write 10, read 10 -> data in order across the 11->0 boundary, level returns to 0, no errors.
- Simultaneous rd_en & wr_en: at level=0 -> write accepted, underflow=1, level=1; at level=12 -> read accepted, overflow=1, level=11; at level=5 -> level stays 5, order preserved.
- Thresholds: ae_thresh=2, af_thresh=10 -> almost_empty=1 for level 0..2, 0 at 3; almost_full=0 at 9, 1 at 10..12; changing af_thresh to 9 at level 9 asserts almost_full in the same cycle.
- FWFT=1: write 0xA5 into empty FIFO -> next cycle empty=0, data_out=0xA5 with no rd_en; rd_en pulse -> empty=1 next cycle, level=0.
- Flush with overflow=1 at level 7, wr_en=1 and rd_en=1 asserted in the same cycle -> next cycle level=0, empty=1, overflow still 1, no new data stored; err_clr -> overflow=0; rst mid-burst -> all state cleared next cycle.
